// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root sequencer: state width and the fixed state codes.
package sqrt_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE  = 4'd0;
  localparam logic [ST_W-1:0] ST_FIRST = 4'd1;
  localparam logic [ST_W-1:0] ST_LAST  = 4'd7;
  localparam logic [ST_W-1:0] ST_DONE  = 4'd8;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_COMPUTE = 2'd1,
    PH_DONE    = 2'd2,
    PH_ILLEGAL = 2'd3
  } phase_t;

  function automatic phase_t phase_of(input logic [ST_W-1:0] q);
    if (q == ST_IDLE)                       return PH_IDLE;
    else if (q >= ST_FIRST && q <= ST_LAST) return PH_COMPUTE;
    else if (q == ST_DONE)                  return PH_DONE;
    else                                    return PH_ILLEGAL;
  endfunction

endpackage

// File: rtl/sqrt_seq_fsm.sv
// State sequencer for the square-root datapath: steps Q through 0..8 with start/ack handshake.
// Optional single-step control of the compute phase is enabled with SQRT_SEQ_STEP_EN.
module sqrt_seq_fsm
  import sqrt_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            ack,
  input  logic            abort,
`ifdef SQRT_SEQ_STEP_EN
  input  logic            step_mode,
  input  logic            step,
`endif
  output logic [ST_W-1:0] Q,
  output logic            ready,
  output logic            busy,
  output logic            err
);

  logic   advance;
  phase_t phase;

`ifdef SQRT_SEQ_STEP_EN
  assign advance = !step_mode || step;
`else
  assign advance = 1'b1;
`endif

  assign phase = phase_of(Q);

  // Abort outranks illegal-code recovery, so an abort from an illegal code leaves err untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Q   <= ST_IDLE;
      err <= 1'b0;
    end else if (abort) begin
      Q <= ST_IDLE;
    end else begin
      unique case (phase)
        PH_IDLE: begin
          if (start) Q <= ST_FIRST;
        end
        PH_COMPUTE: begin
          if (advance) Q <= Q + 4'd1;
        end
        PH_DONE: begin
          if (ack) Q <= ST_IDLE;
        end
        PH_ILLEGAL: begin
          Q   <= ST_IDLE;
          err <= 1'b1;
        end
      endcase
    end
  end

  assign ready = (phase == PH_IDLE);
  assign busy  = (phase == PH_COMPUTE);

endmodule

// File: tb/tb_sqrt_seq_fsm.sv
// Directed-vector bench for sqrt_seq_fsm; step-mode vectors run only with SQRT_SEQ_STEP_EN.
module tb_sqrt_seq_fsm;

  logic       clk = 1'b0;
  logic       rst_n, start, ack, abort;
  logic [3:0] Q;
  logic       ready, busy, err;
`ifdef SQRT_SEQ_STEP_EN
  logic       step_mode, step;
`endif

  int total = 0;
  int bad   = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  sqrt_seq_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ack       (ack),
    .abort     (abort),
`ifdef SQRT_SEQ_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .Q         (Q),
    .ready     (ready),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    total++;
    if (obs !== exp_val) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0;
`ifdef SQRT_SEQ_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    tick(); tick();
    check("rst_q", Q, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", Q, 0);

    // Single-cycle start: 1..7 then 8
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("run_q%0d", i), Q, i);
      if (busy) busy_cnt++;
      if (i < 8) tick();
    end
    check("busy_cycles", busy_cnt, 7);

    // DONE holds without ack, start ignored
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold", Q, 8);
    end
    start = 1'b0;
    check("done_busy", busy, 0);

    ack = 1'b1;
    tick();
    check("ack_q", Q, 0);
    check("ack_ready", ready, 1);
    tick();
    check("ack_held_idle", Q, 0);
    ack = 1'b0;

    // Abort at Q=5
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("pre_abort_q", Q, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_q", Q, 0);
    check("abort_err", err, 0);

    // Illegal code 12
    force dut.Q = 4'd12;
    #1;
    release dut.Q;
    tick();
    check("illegal_q", Q, 0);
    check("illegal_err", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    check("err_run_q", Q, 8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("err_run_idle", Q, 0);
    check("err_sticky", err, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("err_cleared", err, 0);

    // Reset mid-run at Q=3, start held through release
    start = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_q", Q, 3);
    rst_n = 1'b0;
    tick();
    check("midrst_q", Q, 0);
    rst_n = 1'b1;
    tick();
    check("restart_q", Q, 1);
    start = 1'b0;

    // Run to DONE, then abort and ack together
    repeat (7) tick();
    check("pre_both_q", Q, 8);
    abort = 1'b1; ack = 1'b1;
    tick();
    abort = 1'b0; ack = 1'b0;
    check("abort_ack_q", Q, 0);

    // start held high: back-to-back runs
    start = 1'b1;
    tick();
    check("b2b_q1", Q, 1);
    repeat (7) tick();
    check("b2b_q8", Q, 8);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("b2b_idle", Q, 0);
    tick();
    check("b2b_rerun", Q, 1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

`ifdef SQRT_SEQ_STEP_EN
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("step_q1", Q, 1);
    for (int p = 2; p <= 8; p++) begin
      tick();
      tick();
      check("step_hold", Q, p - 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      check($sformatf("step_q%0d", p), Q, p);
    end
    step_mode = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("step_idle", Q, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
